// File: rtl/ser_pkg.sv
// Shared definitions for the serial transmit/detect path: FSM state
// encoding, the line idle level and the default bit-period divider.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_tx_state_t;

  localparam logic SER_IDLE_LVL    = 1'b0;
  localparam int   SER_DIV_DEFAULT = 3;

endpackage

// File: rtl/ser_tick_gen.sv
// Bit-period divider: counts 0..DIV-1 while enabled and flags the last
// cycle of each period with tick. A synchronous clear restarts the period.
module ser_tick_gen
  import ser_pkg::*;
#(
  parameter int DIV = SER_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign tick = en && (count == CNT_MAX);

  // Period counter, wraps to zero on tick so periods run back to back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/ser_tx_frame.sv
// Parallel-in, serial-out frame transmitter. Words are accepted over a
// valid/ready handshake and shifted out MSB-first, DIV cycles per bit,
// with a one-cycle bit_stb at the start of each bit period.
// Optional feature: define SER_TX_PARITY_EN to append an even parity bit.
module ser_tx_frame
  import ser_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV    = SER_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              ser_out,
  output logic              bit_stb,
  output logic              busy,
  output logic              frame_done
);

  localparam int            IW       = $clog2(DATA_W);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  ser_tx_state_t     state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [IW-1:0]     idx, idx_n;
  logic              stb_n;
  logic              done_n;
  logic              tick;
  logic              accept;
  logic              last_bit;
  logic              frame_end;
`ifdef SER_TX_PARITY_EN
  logic              par, par_n;
`endif

  ser_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .clr  (accept),
    .tick (tick)
  );

  // The line bit is simply the top of the shift register, which is
  // loaded with the idle level whenever no frame is in flight.
  assign ser_out = shreg[DATA_W-1];
  assign busy    = (state != IDLE);

`ifdef SER_TX_PARITY_EN
  assign last_bit = (state == PARITY);
`else
  assign last_bit = (state == SHIFT) && (idx == IDX_LAST);
`endif

  // Ready in IDLE and in the final cycle of a frame so frames can stream
  assign frame_end = tick && last_bit;
  assign din_ready = !rst && ((state == IDLE) || frame_end);
  assign accept    = din_valid && din_ready;

  // Next-state and datapath: advance bits on tick, finish or reload at frame end
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    idx_n   = idx;
    stb_n   = 1'b0;
    done_n  = 1'b0;
`ifdef SER_TX_PARITY_EN
    par_n   = par;
`endif
    case (state)
      SHIFT: begin
        if (tick && (idx != IDX_LAST)) begin
          shreg_n = shreg << 1;
          idx_n   = idx + IW'(1);
          stb_n   = 1'b1;
        end
`ifdef SER_TX_PARITY_EN
        else if (tick) begin
          state_n = PARITY;
          shreg_n = {par, {(DATA_W-1){1'b0}}};
          stb_n   = 1'b1;
        end
`endif
      end
      default: ;
    endcase
    if (frame_end) begin
      done_n  = 1'b1;
      state_n = IDLE;
      shreg_n = {DATA_W{SER_IDLE_LVL}};
      idx_n   = '0;
    end
    if (accept) begin
      state_n = SHIFT;
      shreg_n = din;
      idx_n   = '0;
      stb_n   = 1'b1;
`ifdef SER_TX_PARITY_EN
      par_n   = ^din;
`endif
    end
  end

  // State and datapath registers, cleared immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= {DATA_W{SER_IDLE_LVL}};
      idx        <= '0;
      bit_stb    <= 1'b0;
      frame_done <= 1'b0;
`ifdef SER_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      idx        <= idx_n;
      bit_stb    <= stb_n;
      frame_done <= done_n;
`ifdef SER_TX_PARITY_EN
      par        <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_ser_tx_frame.sv
// Scoreboard bench for ser_tx_frame. Main instance: DATA_W=4, DIV=3.
// A second instance with DIV=1 covers the every-cycle tick case.
module tb_ser_tx_frame;

  localparam int DATA_W = 4;
  localparam int DIV    = 3;
`ifdef SER_TX_PARITY_EN
  localparam int NBITS  = DATA_W + 1;
`else
  localparam int NBITS  = DATA_W;
`endif
  localparam int FRAME_CYC = NBITS * DIV;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] din = '0;
  logic              din_valid = 1'b0;
  logic              din_ready, ser_out, bit_stb, busy, frame_done;

  logic [DATA_W-1:0] din1 = '0;
  logic              din_valid1 = 1'b0;
  logic              din_ready1, ser_out1, bit_stb1, busy1, frame_done1;

  ser_tx_frame #(.DATA_W(DATA_W), .DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .ser_out    (ser_out),
    .bit_stb    (bit_stb),
    .busy       (busy),
    .frame_done (frame_done)
  );

  ser_tx_frame #(.DATA_W(DATA_W), .DIV(1)) dut_div1 (
    .clk        (clk),
    .rst        (rst),
    .din        (din1),
    .din_valid  (din_valid1),
    .din_ready  (din_ready1),
    .ser_out    (ser_out1),
    .bit_stb    (bit_stb1),
    .busy       (busy1),
    .frame_done (frame_done1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] word;
    int                e0;
  } frame_t;

  frame_t fq[$];
  logic   bq[$];
  int     cyc      = 0;
  int     last_end = 0;
  int     checks   = 0;
  int     errors   = 0;

  logic   exp_ser, exp_stb, exp_busy, exp_done, exp_ready, exp_b;
  int     off;

  // Reference: bit k of a frame is data MSB-first, then the even parity bit
  function automatic logic expBit(input logic [DATA_W-1:0] w, input int k);
    if (k < DATA_W) return w[DATA_W-1-k];
    return ^w;
  endfunction

  // The block may take a word when no frame is running or in a frame's last cycle
  function automatic bit modelReady(input int c);
    return (c >= last_end) || (c == last_end - 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d",
               name, actual, expected, cyc);
    end
  endtask

  // Drive one cycle of input at the falling edge and record any accept
  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d,
                               output bit acc);
    int e0;
    @(negedge clk);
    din_valid = v;
    din       = d;
    acc       = v && !rst && modelReady(cyc);
    if (acc) begin
      e0 = cyc + 1;
      fq.push_back('{word: d, e0: e0});
      for (int k = 0; k < NBITS; k++) bq.push_back(expBit(d, k));
      last_end = e0 + FRAME_CYC;
    end
  endtask

  task automatic sendWord(input logic [DATA_W-1:0] w);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 64) begin
      applyStimulus(1'b1, w, acc);
      tries++;
    end
    if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idleCycles(input int n);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, DATA_W'($urandom), acc);
  endtask

  // Monitor: per-cycle comparison against the frame timeline, plus bit pops on strobe
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      checkOutput("rst_ser_out", ser_out, 32'd0);
      checkOutput("rst_bit_stb", bit_stb, 32'd0);
      checkOutput("rst_busy", busy, 32'd0);
      checkOutput("rst_frame_done", frame_done, 32'd0);
      checkOutput("rst_din_ready", din_ready, 32'd0);
    end else begin
      exp_done = 1'b0;
      if (fq.size() > 0 && cyc == fq[0].e0 + FRAME_CYC) begin
        exp_done = 1'b1;
        void'(fq.pop_front());
      end
      exp_busy = (fq.size() > 0) && (cyc >= fq[0].e0);
      if (exp_busy) begin
        off       = cyc - fq[0].e0;
        exp_ser   = expBit(fq[0].word, off / DIV);
        exp_stb   = (off % DIV) == 0;
        exp_ready = (off == FRAME_CYC - 1);
      end else begin
        exp_ser   = 1'b0;
        exp_stb   = 1'b0;
        exp_ready = 1'b1;
      end
      checkOutput("ser_out", ser_out, exp_ser);
      checkOutput("bit_stb", bit_stb, exp_stb);
      checkOutput("busy", busy, exp_busy);
      checkOutput("frame_done", frame_done, exp_done);
      checkOutput("din_ready", din_ready, exp_ready);
      if (bit_stb === 1'b1) begin
        if (bq.size() == 0) begin
          checkOutput("strobe_without_bit", 32'd1, 32'd0);
        end else begin
          exp_b = bq.pop_front();
          checkOutput("strobed_bit", ser_out, exp_b);
        end
      end
    end
  end

  // Directed DIV=1 frame: one bit per cycle, strobe every cycle
  task automatic runDiv1();
    logic [DATA_W-1:0] w;
    w = 4'b1011;
    @(negedge clk);
    din1       = w;
    din_valid1 = 1'b1;
    #1 checkOutput("div1_ready_idle", din_ready1, 32'd1);
    @(negedge clk);
    din_valid1 = 1'b0;
    for (int k = 0; k < NBITS; k++) begin
      checkOutput("div1_ser_out", ser_out1, expBit(w, k));
      checkOutput("div1_bit_stb", bit_stb1, 32'd1);
      checkOutput("div1_busy", busy1, 32'd1);
      checkOutput("div1_ready", din_ready1, (k == NBITS - 1) ? 32'd1 : 32'd0);
      checkOutput("div1_done_early", frame_done1, 32'd0);
      @(negedge clk);
    end
    checkOutput("div1_frame_done", frame_done1, 32'd1);
    checkOutput("div1_busy_end", busy1, 32'd0);
    checkOutput("div1_ser_idle", ser_out1, 32'd0);
    checkOutput("div1_stb_end", bit_stb1, 32'd0);
  endtask

  // Reset during bit 2 of a frame, then confirm a clean restart
  task automatic resetMidFrame();
    bit acc;
    sendWord(4'b1011);
    for (int i = 0; i < 2 * DIV + 2; i++) applyStimulus(1'b0, DATA_W'($urandom), acc);
    #2;
    checkOutput("pre_reset_busy", busy, 32'd1);
    checkOutput("pre_reset_ser_out", ser_out, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_ser_out", ser_out, 32'd0);
    checkOutput("mid_rst_busy", busy, 32'd0);
    checkOutput("mid_rst_bit_stb", bit_stb, 32'd0);
    checkOutput("mid_rst_frame_done", frame_done, 32'd0);
    checkOutput("mid_rst_din_ready", din_ready, 32'd0);
    fq.delete();
    bq.delete();
    last_end = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("post_rst_din_ready", din_ready, 32'd1);
    sendWord(4'b0110);
    idleCycles(FRAME_CYC + 2);
  endtask

  initial begin
    bit acc;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("ready_after_reset", din_ready, 32'd1);

    runDiv1();

    $display("[TB] single frame");
    sendWord(4'b1011);
    idleCycles(FRAME_CYC + 3);

    $display("[TB] back-to-back frames");
    sendWord(4'b1011);
    sendWord(4'b0110);
    idleCycles(FRAME_CYC + 3);

    $display("[TB] mid-frame reset");
    resetMidFrame();

    $display("[TB] idle for 50 cycles");
    idleCycles(50);

    $display("[TB] random stream");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, DATA_W'($urandom), acc);
    end
    idleCycles(FRAME_CYC + 3);

    checkOutput("frames_drained", fq.size(), 32'd0);
    checkOutput("bits_drained", bq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ser_tx_frame.md
# ser_tx_frame

Parallel-in, serial-out frame transmitter that produces the single-bit serial stream consumed by the downstream sequence-detector stage. It accepts words over a valid/ready handshake and shifts them out MSB-first, holding each bit for a fixed number of clock cycles. A single-cycle bit strobe marks the start of each bit period, so the consumer can sample without a derived clock. The block sits between the word source and the serial detector, in the same clock domain.

## Interface
- `DATA_W`, default 8: word width in bits; must be ≥ 2.
- `DIV`, default 3: clock cycles per bit period; must be ≥ 1.
- `clk`  in  1: sole clock; everything is on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high. The clock is named `clk` and the reset `rst`.
- `din`  in  DATA_W: word to transmit.
- `din_valid`  in  1: `din` is valid.
- `din_ready`  out  1: the block can accept a word. Combinational from state and tick; forced to 0 while `rst` is high.
- `ser_out`  out  1: serial bit, registered; idle level is 0.
- `bit_stb`  out  1: one-cycle pulse in the first cycle of every bit period, parity bit included.
- `busy`  out  1: high while a frame is in flight.
- `frame_done`  out  1: one-cycle pulse when the last bit period of a frame ends.

## Operation
- States: IDLE, SHIFT, PARITY. PARITY exists only with the macro defined.
- Accept occurs when `din_valid && din_ready` at a rising edge.
- `din_ready` is high in IDLE. It is also high in the final cycle of the frame's last bit period, which allows back-to-back frames.
- On accept:
  - The shift register loads `din`.
  - The bit index and divider counter clear.
  - `ser_out` takes `din[DATA_W-1]`.
  - State goes to SHIFT.
- The divider counter counts 0..DIV-1 while not in IDLE. `tick` = (count == DIV-1). The counter width is max(1, clog2(DIV)).
- On `tick` in SHIFT with more bits remaining: shift left, drive the next bit, and increment the index.
- On `tick` at the last data bit, or in PARITY:
  - `frame_done` is 1 in the next cycle.
  - If a new accept happens on the same edge, the new word loads with no gap.
  - Otherwise state goes to IDLE and `ser_out` returns to 0.
- `din` is ignored unless an accept occurs. The word is captured on the accept edge.
- Reset, including mid-frame, is immediate:
  - State goes to IDLE and all counters go to 0.
  - `ser_out`, `bit_stb`, `busy` and `frame_done` go to 0.
  - The partial frame is discarded and not resumed.
- Reset values: `ser_out`=0, `bit_stb`=0, `busy`=0, `frame_done`=0, `din_ready`=0 during reset and 1 after release.

## Timing
- Let the accept edge be E0 and let N be DATA_W, or DATA_W+1 with parity.
- Bit k (k = 0..N-1) is on `ser_out` from edge E0+k·DIV to edge E0+(k+1)·DIV.
- `bit_stb` is high in the cycle after edge E0+k·DIV, for each k.
- `busy` is high from the cycle after E0 through the cycle before E0+N·DIV.
- `frame_done` is high in the cycle after edge E0+N·DIV.
- `din_ready` is high in the cycle before edge E0+N·DIV.
- Streaming throughput is exactly one frame per N·DIV cycles, with no idle bit.
- When DIV = 1, `tick` is high every cycle and `bit_stb` is high every cycle of a frame.
- Latency from accept to first bit on `ser_out`: 1 edge.

## Configuration
- `SER_TX_PARITY_EN` defined:
  - After the last data bit, the block enters PARITY for one bit period.
  - `ser_out` carries the even parity bit, the XOR of the captured word.
  - `bit_stb` pulses for the parity bit.
  - Frame length is DATA_W+1 bits.
- `SER_TX_PARITY_EN` undefined: no PARITY state and frame length is DATA_W bits.

## Structure
- Shared package `ser_pkg` holds:
  - the state enum `ser_tx_state_t` (IDLE, SHIFT, PARITY);
  - the idle-level constant `SER_IDLE_LVL = 1'b0`;
  - the default `DIV`.
- Sub-module `ser_tick_gen` is the bit-period divider. It has an enable and a synchronous clear, and outputs `tick`. The downstream detector stage reuses it.

## Test plan
- **Single frame.** DATA_W=4, DIV=3, no parity. Accept `4'b1011` at E0.
  - `ser_out` = 1,0,1,1, each bit for 3 cycles.
  - `bit_stb` is high in cycles E0+1, +4, +7, +10.
  - `frame_done` is high in cycle E0+13, and `ser_out` is 0 afterwards.
- **Back-to-back.** Hold `din_valid` and send `4'b1011` then `4'b0110`.
  - `ser_out` = 1011 0110 with no gap.
  - `frame_done` pulses at E0+13 and E0+25.
  - `din_ready` is high only in cycles E0+12 and E0+24 while streaming.
- **Parity.** With `SER_TX_PARITY_EN`, send `4'b1011`.
  - `ser_out` = 1,0,1,1,1, with parity bit = 1.
  - `frame_done` is high at E0+16.
  - Sending `4'b0110` gives parity bit 0.
- **Mid-frame reset.** Assert `rst` during bit 2.
  - `ser_out`, `busy`, `bit_stb` and `frame_done` go to 0 immediately.
  - After release, `din_ready` = 1, and the next frame transmits fully and correctly.
- **Idle and divider edge case.**
  - With `din_valid` held 0 for 50 cycles, `ser_out` stays 0, `busy` stays 0 and `bit_stb` never pulses.
  - With DIV=1, `4'b1011` completes in 4 cycles and `bit_stb` is high for 4 consecutive cycles.
